// File: rtl/mmu_request_buffer_pkg.sv
// Shared request-entry layout for the MMU request buffer: widths, field offsets
// and the packed entry type used by the top module and its storage array.
package mmu_request_buffer_pkg;

    localparam int MMU_REQ_ENTRY_W = 106;

    // Bit offsets of each field inside the packed 106-bit entry.
    localparam int MMU_REQ_DATA_LSB           = 0;
    localparam int MMU_REQ_ADDR_LSB           = 32;
    localparam int MMU_REQ_PDT_LSB            = 64;
    localparam int MMU_REQ_RW_LSB             = 96;
    localparam int MMU_REQ_MASK_LSB           = 97;
    localparam int MMU_REQ_ORDER_LSB          = 101;
    localparam int MMU_REQ_MODE_LSB           = 103;
    localparam int MMU_REQ_DATA_STORE_ACK_LSB = 105;

    typedef struct packed {
        logic        data_store_ack;
        logic [1:0]  mode;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic        rw;
        logic [31:0] pdt;
        logic [31:0] addr;
        logic [31:0] data;
    } mmu_req_t;

    function automatic mmu_req_t pack_req(
        input logic        data_store_ack,
        input logic [1:0]  mode,
        input logic [1:0]  order,
        input logic [3:0]  mask,
        input logic        rw,
        input logic [31:0] pdt,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        mmu_req_t r;
        r.data_store_ack = data_store_ack;
        r.mode           = mode;
        r.order          = order;
        r.mask           = mask;
        r.rw             = rw;
        r.pdt            = pdt;
        r.addr           = addr;
        r.data           = data;
        return r;
    endfunction

endpackage

// File: rtl/mmu_request_buffer_mem.sv
// Request storage: P_DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are not reset; the top qualifies them by count.
module mmu_request_buffer_mem
    import mmu_request_buffer_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
)(
    input  logic                 iCLOCK,
    input  logic                 iWE,
    input  logic [P_DEPTH_N-1:0] iWADDR,
    input  mmu_req_t             iWDATA,
    input  logic [P_DEPTH_N-1:0] iRADDR,
    output mmu_req_t             oRDATA
);

    mmu_req_t mem [P_DEPTH];

    always_ff @(posedge iCLOCK) begin
        if (iWE) begin
            mem[iWADDR] <= iWDATA;
        end
    end

    assign oRDATA = mem[iRADDR];

endmodule

// File: rtl/mmu_request_buffer.sv
// In-order request FIFO between the load/store unit and the MMU logic port.
// Optional zero-latency bypass when empty: define MMU_REQUEST_BUFFER_BYPASS_EN.
module mmu_request_buffer
    import mmu_request_buffer_pkg::*;
#(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2
)(
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFLUSH,
    input  logic                 iREQ,
    output logic                 oLOCK,
    input  logic                 iDATA_STORE_ACK,
    input  logic [1:0]           iMODE,
    input  logic [1:0]           iORDER,
    input  logic [3:0]           iMASK,
    input  logic                 iRW,
    input  logic [31:0]          iPDT,
    input  logic [31:0]          iADDR,
    input  logic [31:0]          iDATA,
    output logic                 oLOGIC_REQ,
    input  logic                 iLOGIC_LOCK,
    output logic                 oLOGIC_DATA_STORE_ACK,
    output logic [1:0]           oLOGIC_MODE,
    output logic [1:0]           oLOGIC_ORDER,
    output logic [3:0]           oLOGIC_MASK,
    output logic                 oLOGIC_RW,
    output logic [31:0]          oLOGIC_PDT,
    output logic [31:0]          oLOGIC_ADDR,
    output logic [31:0]          oLOGIC_DATA,
    output logic [P_DEPTH_N:0]   oCOUNT,
    output logic                 oOVERFLOW
);

    // Handshake: a request moves upstream->buffer on any cycle iREQ is high and
    // the entry is accepted (not full, or full with a same-cycle pop, no flush);
    // oLOCK is advisory one cycle early. Toward the MMU, oLOGIC_REQ is valid and
    // !iLOGIC_LOCK is ready; the head transfers on a cycle where both hold, and
    // the head fields stay stable until then.

    localparam logic [P_DEPTH_N:0]   DEPTH_C = P_DEPTH[P_DEPTH_N:0];
    localparam logic [P_DEPTH_N:0]   LOCK_C  = DEPTH_C - 1'b1;
    localparam logic [P_DEPTH_N:0]   CNT_ONE = 1;
    localparam logic [P_DEPTH_N-1:0] PTR_ONE = 1;

    logic [P_DEPTH_N:0]   count_r;
    logic [P_DEPTH_N-1:0] wptr_r;
    logic [P_DEPTH_N-1:0] rptr_r;
    logic                 overflow_r;

    mmu_req_t in_entry;
    mmu_req_t head_entry;
    mmu_req_t out_entry;

    logic stored_valid;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic drop;

    assign in_entry = pack_req(iDATA_STORE_ACK, iMODE, iORDER, iMASK, iRW,
                               iPDT, iADDR, iDATA);

    assign stored_valid = (count_r != '0);
    assign full         = (count_r == DEPTH_C);
    assign pop          = stored_valid && !iLOGIC_LOCK;

`ifdef MMU_REQUEST_BUFFER_BYPASS_EN
    // An empty buffer with a ready MMU hands the request straight through.
    assign bypass = !stored_valid && iREQ && !iFLUSH && !iLOGIC_LOCK;
`else
    assign bypass = 1'b0;
`endif

    assign push = iREQ && !iFLUSH && !bypass && (!full || pop);
    assign drop = iREQ && !iFLUSH && full && !pop;

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            count_r    <= '0;
            wptr_r     <= '0;
            rptr_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (iFLUSH) begin
                count_r <= '0;
                wptr_r  <= '0;
                rptr_r  <= '0;
            end else begin
                if (push) begin
                    wptr_r <= wptr_r + PTR_ONE;
                end
                if (pop) begin
                    rptr_r <= rptr_r + PTR_ONE;
                end
                if (push && !pop) begin
                    count_r <= count_r + CNT_ONE;
                end else if (pop && !push) begin
                    count_r <= count_r - CNT_ONE;
                end
            end
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    mmu_request_buffer_mem #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N)
    ) u_mem (
        .iCLOCK (iCLOCK),
        .iWE    (push),
        .iWADDR (wptr_r),
        .iWDATA (in_entry),
        .iRADDR (rptr_r),
        .oRDATA (head_entry)
    );

    // Fields read as zero whenever nothing valid is presented.
    always_comb begin
        out_entry = '0;
        if (stored_valid) begin
            out_entry = head_entry;
        end else if (bypass) begin
            out_entry = in_entry;
        end
    end

    assign oLOGIC_REQ            = stored_valid || bypass;
    assign oLOGIC_DATA_STORE_ACK = out_entry.data_store_ack;
    assign oLOGIC_MODE           = out_entry.mode;
    assign oLOGIC_ORDER          = out_entry.order;
    assign oLOGIC_MASK           = out_entry.mask;
    assign oLOGIC_RW             = out_entry.rw;
    assign oLOGIC_PDT            = out_entry.pdt;
    assign oLOGIC_ADDR           = out_entry.addr;
    assign oLOGIC_DATA           = out_entry.data;

    assign oLOCK     = (count_r >= LOCK_C);
    assign oCOUNT    = count_r;
    assign oOVERFLOW = overflow_r;

endmodule

// File: tb/tb_mmu_request_buffer.sv
// Bench for mmu_request_buffer: directed stimulus, expected entries queued on
// acceptance and compared by an independent monitor at the MMU port.
module tb_mmu_request_buffer;

    localparam int DEPTH = 4;

    logic        iCLOCK;
    logic        inRESET;
    logic        iFLUSH;
    logic        iREQ;
    logic        oLOCK;
    logic        iDATA_STORE_ACK;
    logic [1:0]  iMODE;
    logic [1:0]  iORDER;
    logic [3:0]  iMASK;
    logic        iRW;
    logic [31:0] iPDT;
    logic [31:0] iADDR;
    logic [31:0] iDATA;
    logic        oLOGIC_REQ;
    logic        iLOGIC_LOCK;
    logic        oLOGIC_DATA_STORE_ACK;
    logic [1:0]  oLOGIC_MODE;
    logic [1:0]  oLOGIC_ORDER;
    logic [3:0]  oLOGIC_MASK;
    logic        oLOGIC_RW;
    logic [31:0] oLOGIC_PDT;
    logic [31:0] oLOGIC_ADDR;
    logic [31:0] oLOGIC_DATA;
    logic [2:0]  oCOUNT;
    logic        oOVERFLOW;

    logic [105:0] exp_q[$];
    logic [105:0] in_vec;
    logic [105:0] out_vec;
    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int mcnt     = 0;

    mmu_request_buffer #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
        .iCLOCK                (iCLOCK),
        .inRESET               (inRESET),
        .iFLUSH                (iFLUSH),
        .iREQ                  (iREQ),
        .oLOCK                 (oLOCK),
        .iDATA_STORE_ACK       (iDATA_STORE_ACK),
        .iMODE                 (iMODE),
        .iORDER                (iORDER),
        .iMASK                 (iMASK),
        .iRW                   (iRW),
        .iPDT                  (iPDT),
        .iADDR                 (iADDR),
        .iDATA                 (iDATA),
        .oLOGIC_REQ            (oLOGIC_REQ),
        .iLOGIC_LOCK           (iLOGIC_LOCK),
        .oLOGIC_DATA_STORE_ACK (oLOGIC_DATA_STORE_ACK),
        .oLOGIC_MODE           (oLOGIC_MODE),
        .oLOGIC_ORDER          (oLOGIC_ORDER),
        .oLOGIC_MASK           (oLOGIC_MASK),
        .oLOGIC_RW             (oLOGIC_RW),
        .oLOGIC_PDT            (oLOGIC_PDT),
        .oLOGIC_ADDR           (oLOGIC_ADDR),
        .oLOGIC_DATA           (oLOGIC_DATA),
        .oCOUNT                (oCOUNT),
        .oOVERFLOW             (oOVERFLOW)
    );

    assign in_vec  = {iDATA_STORE_ACK, iMODE, iORDER, iMASK, iRW, iPDT, iADDR, iDATA};
    assign out_vec = {oLOGIC_DATA_STORE_ACK, oLOGIC_MODE, oLOGIC_ORDER, oLOGIC_MASK,
                      oLOGIC_RW, oLOGIC_PDT, oLOGIC_ADDR, oLOGIC_DATA};

    // ---------------- clock / reset ----------------
    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [105:0] mk(input int i);
        logic [31:0] u;
        u = i;
        return {u[0], u[1:0], u[2:1], u[3:0] ^ 4'h5, u[1],
                32'h1000_0000 + u, 32'h0000_4000 + (u << 2), 32'hA5A5_0000 ^ u};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [105:0] act, input logic [105:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic set_req(input logic [105:0] e);
        iREQ = 1'b1;
        {iDATA_STORE_ACK, iMODE, iORDER, iMASK, iRW, iPDT, iADDR, iDATA} = e;
    endtask

    task automatic clr_req();
        iREQ = 1'b0;
        {iDATA_STORE_ACK, iMODE, iORDER, iMASK, iRW, iPDT, iADDR, iDATA} = '0;
    endtask

    // ---------------- reference model: acceptance -> expected queue ----------------
    always @(posedge iCLOCK) begin
        int m_pop;
        int m_push;
        int m_byp;
        if (!inRESET || iFLUSH) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            m_pop = (mcnt != 0 && !iLOGIC_LOCK) ? 1 : 0;
            m_byp = 0;
`ifdef MMU_REQUEST_BUFFER_BYPASS_EN
            m_byp = (mcnt == 0 && iREQ && !iLOGIC_LOCK) ? 1 : 0;
`endif
            m_push = (iREQ && m_byp == 0 && (mcnt < DEPTH || m_pop == 1)) ? 1 : 0;
            if (m_push == 1) exp_q.push_back(in_vec);
            mcnt = mcnt + m_push - m_pop;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge iCLOCK) begin
        if (inRESET) begin
            if (oLOGIC_REQ) begin
                if (exp_q.size() != 0) begin
                    chk_vec("head_entry", out_vec, exp_q[0]);
                    if (!iLOGIC_LOCK) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end else begin
`ifdef MMU_REQUEST_BUFFER_BYPASS_EN
                    chk_vec("bypass_entry", out_vec, in_vec);
                    chk("bypass_req", {31'd0, iREQ}, 32'd1);
                    pops++;
`else
                    checks++;
                    failures++;
                    $display("FAIL req_when_empty act=1 exp=0");
`endif
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL req_low act=0 exp=1 pending=%0d", exp_q.size());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int sent;
        int budget;
        inRESET     = 1'b0;
        iFLUSH      = 1'b0;
        iLOGIC_LOCK = 1'b0;
        clr_req();
        repeat (2) @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;

        chk("rst_count", {29'd0, oCOUNT}, 32'd0);
        chk("rst_lock", {31'd0, oLOCK}, 32'd0);
        chk("rst_req", {31'd0, oLOGIC_REQ}, 32'd0);
        chk("rst_ovf", {31'd0, oOVERFLOW}, 32'd0);
        chk("rst_addr", oLOGIC_ADDR, 32'd0);

        // single request, MMU ready
        iLOGIC_LOCK = 1'b0;
        set_req({1'b0, 2'd1, 2'd2, 4'hF, 1'b1, 32'h0000_8000, 32'h0000_4000, 32'h1234_5678});
`ifdef MMU_REQUEST_BUFFER_BYPASS_EN
        chk("byp_req", {31'd0, oLOGIC_REQ}, 32'd1);
        chk("byp_addr", oLOGIC_ADDR, 32'h0000_4000);
        chk("byp_rw", {31'd0, oLOGIC_RW}, 32'd1);
        step();
        clr_req();
        chk("byp_count", {29'd0, oCOUNT}, 32'd0);
`else
        step();
        clr_req();
        chk("single_req", {31'd0, oLOGIC_REQ}, 32'd1);
        chk("single_addr", oLOGIC_ADDR, 32'h0000_4000);
        chk("single_rw", {31'd0, oLOGIC_RW}, 32'd1);
        chk("single_count", {29'd0, oCOUNT}, 32'd1);
        step();
`endif
        chk("single_drain", {29'd0, oCOUNT}, 32'd0);

        // fill with MMU stalled, then overflow
        iLOGIC_LOCK = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(mk(k));
            step();
            chk("fill_count", {29'd0, oCOUNT}, k + 1);
            chk("fill_lock", {31'd0, oLOCK}, (k == 2) ? 32'd1 : 32'd0);
        end
        set_req(mk(3));
        step();
        chk("full_count", {29'd0, oCOUNT}, 32'd4);
        chk("full_ovf", {31'd0, oOVERFLOW}, 32'd0);
        set_req(mk(4));
        step();
        chk("drop_count", {29'd0, oCOUNT}, 32'd4);
        chk("drop_ovf", {31'd0, oOVERFLOW}, 32'd1);

        // full queue streaming: push and pop every cycle
        iLOGIC_LOCK = 1'b0;
        for (int k = 5; k < 9; k++) begin
            set_req(mk(k));
            step();
            chk("stream_count", {29'd0, oCOUNT}, 32'd4);
        end
        clr_req();
        repeat (4) step();
        chk("stream_drain", {29'd0, oCOUNT}, 32'd0);
        chk("stream_pops", pops, 32'd9);

        // flush with three entries and a concurrent request
        iLOGIC_LOCK = 1'b1;
        for (int k = 10; k < 13; k++) begin
            set_req(mk(k));
            step();
        end
        chk("preflush_count", {29'd0, oCOUNT}, 32'd3);
        iFLUSH = 1'b1;
        set_req(mk(13));
        step();
        iFLUSH = 1'b0;
        clr_req();
        chk("flush_count", {29'd0, oCOUNT}, 32'd0);
        chk("flush_req", {31'd0, oLOGIC_REQ}, 32'd0);
        chk("flush_ovf", {31'd0, oOVERFLOW}, 32'd1);
        chk("flush_addr", oLOGIC_ADDR, 32'd0);

        // nine requests through the ring with a random MMU stall
        sent   = 0;
        budget = 0;
        while (sent < 9 && budget < 200) begin
            iLOGIC_LOCK = 1'($urandom_range(0, 1));
            if (!oLOCK) begin
                set_req(mk(20 + sent));
                sent++;
            end else begin
                clr_req();
            end
            step();
            budget++;
        end
        clr_req();
        chk("wrap_sent", sent, 32'd9);
        iLOGIC_LOCK = 1'b0;
        budget = 0;
        while (oCOUNT != 0 && budget < 20) begin
            step();
            budget++;
        end
        chk("wrap_drain", {29'd0, oCOUNT}, 32'd0);
        chk("wrap_pending", exp_q.size(), 32'd0);
        chk("wrap_pops", pops, 32'd18);

        // reset mid-occupancy clears everything
        iLOGIC_LOCK = 1'b1;
        set_req(mk(40));
        step();
        set_req(mk(41));
        step();
        clr_req();
        chk("prerst_count", {29'd0, oCOUNT}, 32'd2);
        chk("prerst_ovf", {31'd0, oOVERFLOW}, 32'd1);
        inRESET = 1'b0;
        step();
        chk("rst2_count", {29'd0, oCOUNT}, 32'd0);
        chk("rst2_lock", {31'd0, oLOCK}, 32'd0);
        chk("rst2_req", {31'd0, oLOGIC_REQ}, 32'd0);
        chk("rst2_ovf", {31'd0, oOVERFLOW}, 32'd0);
        chk("rst2_addr", oLOGIC_ADDR, 32'd0);
        chk("rst2_data", oLOGIC_DATA, 32'd0);
        inRESET = 1'b1;
        step();
        chk("post_rst_count", {29'd0, oCOUNT}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
